// File: rtl/alu_sequencer.sv
// Registered calculator controller: latches operands and operation on start, runs
// add/sub in one cycle and multiply/divide as WIDTH-step iterative sequences.
module alu_sequencer #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [15:0]        switches,
  output logic [2*WIDTH:0]   result,
  output logic [WIDTH-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int RW = 2 * WIDTH + 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXEC   = 2'd1;
  localparam logic [1:0] ITER   = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;

  logic [1:0]         state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   x_q, y_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod, mcand;
  logic [WIDTH-1:0]   mplier, quot, rem;

  logic [WIDTH-1:0]   sw_x, sw_y;
  logic [2:0]         op_dec;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;

  assign sw_y = switches[WIDTH-1:0];
  assign sw_x = switches[2*WIDTH-1:WIDTH];

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    op_dec = OP_NONE;
    if (switches[15])      op_dec = OP_ADD;
    else if (switches[14]) op_dec = OP_SUB;
    else if (switches[13]) op_dec = OP_DIV;
    else if (switches[12]) op_dec = OP_MUL;
  end

  // Restoring-division step: the partial remainder is always < Y, so the
  // difference fits in WIDTH bits whenever the trial subtraction succeeds.
  always_comb begin
    div_shift = {rem, quot[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, y_q});
    div_diff  = div_shift[WIDTH-1:0] - y_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_NONE;
      x_q       <= '0;
      y_q       <= '0;
      cnt       <= '0;
      prod      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      quot      <= '0;
      rem       <= '0;
      result    <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_q    <= sw_x;
            y_q    <= sw_y;
            op_q   <= op_dec;
            busy   <= 1'b1;
            err    <= 1'b0;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= {{WIDTH{1'b0}}, sw_x};
            mplier <= sw_y;
            quot   <= sw_x;
            rem    <= '0;
            if (op_dec == OP_MUL || (op_dec == OP_DIV && sw_y != '0)) state <= ITER;
            else                                                      state <= EXEC;
          end
        end
        EXEC: begin
          case (op_q)
            OP_ADD:  result <= RW'(x_q) + RW'(y_q);
            OP_SUB:  result <= RW'(x_q) - RW'(y_q);
            default: result <= '0;
          endcase
          // A DIV only reaches EXEC when its divisor was zero.
          if (op_q == OP_DIV) err <= 1'b1;
          remainder <= '0;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        ITER: begin
          if (op_q == OP_MUL) begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end else begin
            rem  <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], div_ge};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= FINISH;
        end
        default: begin
          if (op_q == OP_MUL) begin
            result    <= {1'b0, prod};
            remainder <= '0;
          end else begin
            result    <= RW'(quot);
            remainder <= rem;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus pushes expected responses, a
// negedge monitor pops and compares them whenever done is presented.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] switches = '0;
  logic [12:0] result;
  logic [5:0]  remainder;
  logic        busy, done, err;

  alu_sequencer #(.WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .switches(switches),
    .result(result), .remainder(remainder), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] res;
    logic [5:0]  rem;
    logic        err;
    int          e0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ndone = 0;

  always @(posedge clk) cyc++;

  task automatic check(string name, longint act, longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, req, req, $time);
    end
  endtask

  // Reference behaviour computed straight from the operation rules.
  function automatic exp_t model(int x, int y, logic [3:0] sel);
    exp_t e;
    int v;
    e.rem = '0; e.err = 1'b0; e.lat = 2; e.e0 = 0; v = 0;
    if (sel[3])      v = x + y;
    else if (sel[2]) v = (x - y) & 8191;
    else if (sel[1]) begin
      if (y == 0) e.err = 1'b1;
      else begin
        v = x / y; e.rem = 6'(x % y); e.lat = 8;
      end
    end else if (sel[0]) begin
      v = x * y; e.lat = 8;
    end
    e.res = 13'(v);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      ndone++;
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("remainder", remainder, e.rem);
        check("err", err, e.err);
        check("latency", cyc - e.e0 + 1, e.lat);
        check("busy_at_done", busy, 0);
      end
    end
  end

  task automatic issue(int x, int y, logic [3:0] sel);
    exp_t e;
    @(negedge clk);
    switches = {sel, 6'(x), 6'(y)};
    start = 1'b1;
    e = model(x, y, sel);
    e.e0 = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    check("err_cleared_on_start", err, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    check("completion_timeout", sb.size(), 0);
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_result"}, result, 0);
    check({tag, "_remainder"}, remainder, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(63, 63, 4'b1001); wait_idle();   // ADD wins over MUL: 126
    issue(3, 30, 4'b0100);  wait_idle();   // SUB wrap: 0x1FE5
    issue(63, 63, 4'b0001); wait_idle();   // MUL 3969
    issue(0, 45, 4'b0001);  wait_idle();
    issue(45, 7, 4'b0010);  wait_idle();   // DIV 6 r 3
    issue(45, 0, 4'b0010);  wait_idle();   // divide by zero
    check("err_holds", err, 1);
    issue(10, 5, 4'b1000);  wait_idle();   // err clears on accept

    // Interference: start pulse and switch toggle mid-MUL.
    d0 = ndone;
    issue(50, 41, 4'b0001);
    repeat (2) @(negedge clk);
    switches = ~switches;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    check("single_done_interference", ndone - d0, 1);

    // Reset in the middle of a DIV.
    d0 = ndone;
    issue(45, 7, 4'b0010);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1 check_zero_outputs("midreset");
    sb.delete();
    repeat (3) @(negedge clk);
    check("no_done_after_reset", ndone - d0, 0);
    begin
      exp_t e;
      rst_n = 1'b1;
      switches = {4'b1000, 6'd1, 6'd2};
      start = 1'b1;
      e = model(1, 2, 4'b1000);
      e.e0 = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_reset_start", busy, 1);
    end
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      int x, y;
      x = $urandom_range(0, 63);
      y = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 63);
      issue(x, y, 4'($urandom_range(0, 15)));
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Registered controller that sits between the Basys3 switch/button inputs and the calculator result display. It latches operands and operation on a start pulse, executes add/subtract in one cycle and multiply/divide as iterative shift-add and restoring-divide sequences, then holds the result. This replaces the free-running combinational `*` and `/` paths with a bounded, timed sequence and adds divide-by-zero detection.

## Interface
Parameters:
- `WIDTH`, default 6: operand width. Result width is `2*WIDTH+1`, which is 13 at the default.

Ports:
- `clk`, input, 1: system clock, 100 MHz on the board.
- `rst_n`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `start`, input, 1: single-cycle pulse from the upstream button debouncer.
- `switches`, input, 16: operand and operation inputs.
  - `[5:0]` is Y.
  - `[11:6]` is X.
  - `[15:12]` is the operation select.
- `result`, output, 13: registered result.
- `remainder`, output, WIDTH: registered division remainder. It is 0 for every other operation.
- `busy`, output, 1: high from the edge that accepts `start` until the edge that asserts `done`.
- `done`, output, 1: one-cycle pulse that marks `result` as valid.
- `err`, output, 1: set on divide-by-zero. It holds until the next accepted `start`.

## Operation
- **Operation decode** is a priority encoder evaluated on the latched `switches[15:12]`:
  - bit 15 selects ADD, and takes priority over all others;
  - otherwise bit 14 selects SUB;
  - otherwise bit 13 selects DIV;
  - otherwise bit 12 selects MUL;
  - if no bit is set, the operation is NONE and the result is 0.
- **States:** IDLE, EXEC, ITER, FINISH.
- **IDLE:**
  - If `start`=1, capture X, Y and the decoded operation, set `busy` and clear `err`.
  - Go to ITER for MUL, or for DIV with Y≠0. Go to EXEC for everything else.
- **EXEC:** write `result` and `remainder`, pulse `done`, clear `busy`, return to IDLE.
  - ADD: `result` = zero-extended X+Y.
  - SUB: `result` = (X−Y) mod 2^13, two's-complement wrap. Example: 3−30 = 13'h1FE5.
  - NONE: `result` = 0.
  - DIV with Y=0: `result` = 0, `remainder` = 0, `err` = 1.
- **ITER:** runs exactly WIDTH cycles on a 0..WIDTH−1 counter, then goes to FINISH.
  - MUL uses an LSB-first shift-add accumulator.
  - DIV uses MSB-first restoring division, one quotient bit per cycle.
- **FINISH:** write `result` and `remainder`, pulse `done`, clear `busy`, return to IDLE.
  - MUL: `result` = X*Y, which is at most 3969 and fits in 12 bits.
  - DIV: `result` = zero-extended quotient; `remainder` = X mod Y.
- **`start` while `busy`=1** is ignored. It is not queued.
- **Switch changes after acceptance** have no effect on the operation in flight.
- **Output hold:** `result`, `remainder` and `err` hold their values between operations. They change only on `done` or on reset; `err` is also cleared on an accepted `start`.
- **Reset:**
  - Asserting `rst_n`=0 at any point, including mid-ITER, immediately forces state IDLE.
  - It also forces `result`=0, `remainder`=0, `busy`=0, `done`=0, `err`=0, and clears the counter and accumulators.
  - After release, the block accepts `start` on the first edge.

## Timing
- Edges are counted from E0, the edge that samples `start`=1 in IDLE.
- **ADD / SUB / NONE / divide-by-zero:**
  - `result` is updated at E1.
  - `done` is high for the cycle after E1.
  - `busy` is high from E0 to E1.
  - Latency is 2 edges.
- **MUL / DIV:**
  - ITER runs at E1..E6, with WIDTH=6.
  - FINISH writes `result` at E7, and `done` is high for the cycle after E7.
  - Latency is WIDTH+2 edges, which is 8 at the default.
- **Back-to-back:** a `start` sampled on the edge where `done` is asserted is ignored, because state is not yet IDLE. The earliest accepted restart is the edge on which `done`=1 is visible, i.e. the first edge after `done` rises.
- **Reset** is asynchronous assert and synchronous-safe deassert. The upstream reset synchronizer is external to this block.
- **Pipelining:** there is none. At most one operation is in flight.

## Test plan
- **ADD with priority:**
  - Stimulus: X=63, Y=63, `switches[15:12]`=4'b1001, pulse `start`.
  - Required: `result`=126 and `done` 2 edges after `start`; `busy` high for exactly 1 cycle; the result proves ADD beat MUL.
- **SUB wrap:**
  - Stimulus: X=3, Y=30, SUB.
  - Required: `result`=13'h1FE5 and `err`=0.
- **MUL:**
  - Stimulus: X=63, Y=63.
  - Required: `result`=3969 with `done` exactly 8 edges after `start`.
  - Stimulus: X=0, Y=45.
  - Required: `result`=0, still at 8-edge latency.
- **DIV:**
  - Stimulus: X=45, Y=7.
  - Required: `result`=6, `remainder`=3, latency 8.
  - Stimulus: next op X=45, Y=0.
  - Required: `result`=0, `err`=1, latency 2; `err` then clears on the next accepted `start`.
- **Interference:**
  - Stimulus: during a MUL, pulse `start` at E3 and toggle all switches.
  - Required: a single `done` with the originally latched product; no second operation runs.
- **Reset mid-operation:**
  - Stimulus: drop `rst_n` at E4 of a DIV.
  - Required: all outputs read 0 immediately, with no `done`.
  - Stimulus: after release, pulse `start` on the first edge with an ADD of 1+2.
  - Required: the ADD is accepted and `result`=3.
